// File: rtl/tia_horizontal_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tia_horizontal_timing_gen
//  Description : Single-clock TIA horizontal timing: counts, sync/burst/blank
//                decode, RSYNC, WSYNC (RDY) and HMOVE late blank / motion clocks.
//  Revision    : 1.0  initial release
// ============================================================================
module tia_horizontal_timing_gen #(
    parameter int CNT_W       = 6,
    parameter int CLK_DIV     = 4,
    parameter int LINE_COUNTS = 57,
    parameter int HSYNC_START = 4,
    parameter int HSYNC_END   = 8,
    parameter int CB_START    = 9,
    parameter int CB_END      = 13,
    parameter int HBLANK_END  = 17,
    parameter int HBLANK_LATE = 19,
    parameter int MOTION_CLKS = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rsyn,
    input  logic                       wsyn,
    input  logic                       hmove,
    input  logic                       vblk,
    output logic [CNT_W-1:0]           hcount,
    output logic [$clog2(CLK_DIV)-1:0] phase,
    output logic                       line_start,
    output logic                       hsync,
    output logic                       cburst,
    output logic                       hblank,
    output logic                       blank,
    output logic                       rdy,
    output logic                       motck
);

    localparam int PH_W  = $clog2(CLK_DIV);
    localparam int MOT_W = $clog2(MOTION_CLKS + 1);

    localparam logic [PH_W-1:0]  c_PH_LAST     = PH_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] c_HC_LAST     = CNT_W'(LINE_COUNTS - 1);
    localparam logic [CNT_W-1:0] c_HSYNC_START = CNT_W'(HSYNC_START);
    localparam logic [CNT_W-1:0] c_HSYNC_END   = CNT_W'(HSYNC_END);
    localparam logic [CNT_W-1:0] c_CB_START    = CNT_W'(CB_START);
    localparam logic [CNT_W-1:0] c_CB_END      = CNT_W'(CB_END);
    localparam logic [CNT_W-1:0] c_HB_END      = CNT_W'(HBLANK_END);
    localparam logic [CNT_W-1:0] c_HB_LATE     = CNT_W'(HBLANK_LATE);
    localparam logic [MOT_W-1:0] c_MOT_LOAD    = MOT_W'(MOTION_CLKS);

    if (!(CLK_DIV >= 2 && HSYNC_START < HSYNC_END && HSYNC_END <= CB_START &&
          CB_START < CB_END && CB_END <= HBLANK_END && HBLANK_END <= HBLANK_LATE &&
          HBLANK_LATE < LINE_COUNTS && LINE_COUNTS <= (2 ** CNT_W))) begin : g_param_error
        $error("tia_horizontal_timing_gen: illegal timing parameter set");
    end

    logic             r_late;
    logic             r_pend;
    logic [MOT_W-1:0] r_mot;

    logic             w_ph_wrap;
    logic [PH_W-1:0]  w_phase_nx;
    logic [CNT_W-1:0] w_hcount_nx;
    logic             w_ls_nx;
    logic             w_hm_early;
    logic             w_pend_or;
    logic             w_late_nx;
    logic             w_pend_nx;
    logic [MOT_W-1:0] w_mot_nx;
    logic             w_motck_nx;
    logic             w_rdy_nx;
    logic             w_hblank_nx;

    always_comb begin
        w_ph_wrap   = (phase == c_PH_LAST);
        w_phase_nx  = phase + 1'b1;
        w_hcount_nx = hcount;
        if (rsyn) begin
            w_phase_nx  = '0;
            w_hcount_nx = '0;
        end else if (w_ph_wrap) begin
            w_phase_nx  = '0;
            w_hcount_nx = (hcount == c_HC_LAST) ? '0 : hcount + 1'b1;
        end
        w_ls_nx = (w_hcount_nx == '0) && (w_phase_nx == '0);

        // An HMOVE seen past the normal blank end lengthens the next line's blank.
        w_hm_early = hmove && (hcount < c_HB_END);
        w_pend_or  = r_pend || (hmove && !(hcount < c_HB_END));
        w_late_nx  = r_late;
        w_pend_nx  = r_pend;
        if (!rsyn) begin
            if (w_ls_nx) begin
                w_late_nx = w_pend_or;
                w_pend_nx = 1'b0;
            end else begin
                w_late_nx = r_late || w_hm_early;
                w_pend_nx = w_pend_or;
            end
        end

        w_mot_nx   = r_mot;
        w_motck_nx = 1'b0;
        if (!rsyn) begin
            if (hmove) begin
                w_mot_nx = c_MOT_LOAD;
            end else if ((r_mot != '0) && (w_phase_nx == '0)) begin
                w_mot_nx   = r_mot - 1'b1;
                w_motck_nx = 1'b1;
            end
        end

        w_rdy_nx = rdy;
        if (rsyn) begin
            w_rdy_nx = 1'b1;
        end else if (wsyn && rdy) begin
            w_rdy_nx = 1'b0;
        end else if (w_ls_nx) begin
            w_rdy_nx = 1'b1;
        end

        w_hblank_nx = w_hcount_nx < (w_late_nx ? c_HB_LATE : c_HB_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount     <= '0;
            phase      <= '0;
            line_start <= 1'b0;
            hsync      <= 1'b0;
            cburst     <= 1'b0;
            hblank     <= 1'b1;
            blank      <= 1'b1;
            rdy        <= 1'b1;
            motck      <= 1'b0;
            r_late     <= 1'b0;
            r_pend     <= 1'b0;
            r_mot      <= '0;
        end else begin
            hcount     <= w_hcount_nx;
            phase      <= w_phase_nx;
            line_start <= w_ls_nx;
            hsync      <= (w_hcount_nx >= c_HSYNC_START) && (w_hcount_nx < c_HSYNC_END);
            cburst     <= (w_hcount_nx >= c_CB_START) && (w_hcount_nx < c_CB_END);
            hblank     <= w_hblank_nx;
            blank      <= w_hblank_nx || vblk;
            rdy        <= w_rdy_nx;
            motck      <= w_motck_nx;
            r_late     <= w_late_nx;
            r_pend     <= w_pend_nx;
            r_mot      <= w_mot_nx;
        end
    end

endmodule
`default_nettype wire
